// File: rtl/entrada_pkg.sv
// Shared types and defaults for the input sequencer and its button debouncer.
package entrada_pkg;

    // Sequencer states: free running / waiting for an IN operand.
    typedef enum logic [1:0] {
        RUN,
        IN_WAIT_REL,
        IN_WAIT_PRESS,
        IN_DONE
    } input_state_t;

    // Defaults sized for the board clock: ~0.6 us debounce, ~32 Hz run-mode CPU rate at 50 MHz.
    localparam int DEB_CYCLES_DEF = 32;
    localparam int RUN_DIV_DEF    = 1562500;

    // Sw[SW_VALID_BIT] flags the value on Sw[SW_VALID_BIT-1:0] as ready to be consumed.
    localparam int SW_VALID_BIT   = 13;

endpackage

// File: rtl/button_debouncer.sv
// Debounces the active-low push-button into a level (Pressed) and a one-cycle press pulse.
module button_debouncer
    import entrada_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Botao,
    output logic Pressed,
    output logic PressEvt
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          pressed_q;
    logic          evt_q;
    logic          sample;
    logic          disagree;

    assign sample   = ~Botao;
    assign disagree = (sample != pressed_q);

    // Count consecutive disagreeing samples; the DEB_CYCLES-th one flips the level.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            if (disagree) begin
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    pressed_q <= sample;
                    evt_q     <= sample;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign Pressed  = pressed_q;
    assign PressEvt = evt_q;

endmodule

// File: rtl/input_sequencer.sv
// CPU clock-enable generator and IN-instruction handshake against the board button/switches.
module input_sequencer
    import entrada_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int RUN_DIV    = RUN_DIV_DEF,
    parameter int DATA_W     = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Botao,
    input  logic [13:0]       Sw,
    input  logic              Pause,
    input  logic              InReq,
    output logic              CpuEn,
    output logic [DATA_W-1:0] DataIn,
    output logic              DataValid,
    output logic              InvalidPress
);

    localparam int DIV_W = $clog2(RUN_DIV);

    logic pressed;
    logic press_evt;

    button_debouncer #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .Clock   (Clock),
        .Reset   (Reset),
        .Botao   (Botao),
        .Pressed (pressed),
        .PressEvt(press_evt)
    );

    input_state_t      state_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              cpu_en_q;
    logic              data_valid_q;
    logic              invalid_q;
    logic [DATA_W-1:0] data_q;
    logic              pulse_due;

    // Run mode: pulse at the divider's terminal count. Step mode: pulse on each debounced press.
    assign pulse_due = Pause ? (div_q == DIV_W'(RUN_DIV - 1)) : press_evt;

    // Divider next value: wraps in run mode, parked at 0 in step mode. Since step mode parks it,
    // any Pause toggle leaves the count at 0.
    always_comb begin
        div_d = '0;
        if (Pause && (div_q != DIV_W'(RUN_DIV - 1)))
            div_d = div_q + DIV_W'(1);
    end

    // Sequencer FSM with registered single-cycle output pulses.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= RUN;
            div_q        <= '0;
            cpu_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
            invalid_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            cpu_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
            invalid_q    <= 1'b0;
            case (state_q)
                RUN: begin
                    div_q <= div_d;
                    if (pulse_due) begin
                        // A pulse landing on an IN instruction is held back until data arrives.
                        if (InReq)
                            state_q <= IN_WAIT_REL;
                        else
                            cpu_en_q <= 1'b1;
                    end
                end
                IN_WAIT_REL: begin
                    // The press that stepped onto the IN must be released before it counts as data.
                    div_q <= '0;
                    if (!pressed)
                        state_q <= IN_WAIT_PRESS;
                end
                IN_WAIT_PRESS: begin
                    div_q <= '0;
                    if (press_evt) begin
                        if (Sw[SW_VALID_BIT]) begin
                            data_q       <= DATA_W'(Sw[SW_VALID_BIT-1:0]);
                            cpu_en_q     <= 1'b1;
                            data_valid_q <= 1'b1;
                            state_q      <= IN_DONE;
                        end else begin
                            invalid_q <= 1'b1;
                        end
                    end
                end
                IN_DONE: begin
                    // CpuEn/DataValid are high during this cycle; restart the divider cleanly.
                    div_q   <= '0;
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign CpuEn        = cpu_en_q;
    assign DataValid    = data_valid_q;
    assign InvalidPress = invalid_q;
    assign DataIn       = data_q;

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench for input_sequencer with DEB_CYCLES=4, RUN_DIV=5, DATA_W=32.
module tb_input_sequencer;
    import entrada_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        Botao;
    logic [13:0] Sw;
    logic        Pause;
    logic        InReq;
    logic        CpuEn;
    logic [31:0] DataIn;
    logic        DataValid;
    logic        InvalidPress;

    int n_cmp;
    int n_err;
    int cnt_cpu;
    int cnt_dv;
    int cnt_inv;

    input_sequencer #(
        .DEB_CYCLES(4),
        .RUN_DIV   (5),
        .DATA_W    (32)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Botao       (Botao),
        .Sw          (Sw),
        .Pause       (Pause),
        .InReq       (InReq),
        .CpuEn       (CpuEn),
        .DataIn      (DataIn),
        .DataValid   (DataValid),
        .InvalidPress(InvalidPress)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Advance n cycles while tallying output pulses.
    task automatic tick_cnt(input int n);
        repeat (n) begin
            @(negedge Clock);
            cnt_cpu += int'(CpuEn);
            cnt_dv  += int'(DataValid);
            cnt_inv += int'(InvalidPress);
        end
    endtask

    task automatic clr_cnt();
        cnt_cpu = 0;
        cnt_dv  = 0;
        cnt_inv = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr_cnt();
        Reset = 1'b0;
        Botao = 1'b1;
        Sw    = 14'h0000;
        Pause = 1'b1;
        InReq = 1'b0;

        // Reset held for 3 edges
        tick(3);
        chk("rst_cpuen", 32'(CpuEn), 32'd0);
        chk("rst_datain", DataIn, 32'd0);
        chk("rst_dv", 32'(DataValid), 32'd0);
        chk("rst_inv", 32'(InvalidPress), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(RUN));

        // Run mode: pulses on cycles 5, 10, 15 after release
        Reset = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick(1);
            chk($sformatf("run_pulse_t%0d", t), 32'(CpuEn), (t % 5 == 0) ? 32'd1 : 32'd0);
        end
        chk("run_datain", DataIn, 32'd0);

        // Step mode: 3-cycle bounce gives nothing, 6-cycle press gives one pulse
        Pause = 1'b0;
        Botao = 1'b0;
        clr_cnt();
        tick_cnt(3);
        Botao = 1'b1;
        tick_cnt(8);
        chk("bounce_no_pulse", 32'(cnt_cpu), 32'd0);
        Botao = 1'b0;
        clr_cnt();
        tick_cnt(6);
        Botao = 1'b1;
        tick_cnt(8);
        chk("step_one_pulse", 32'(cnt_cpu), 32'd1);

        // Run mode, InReq raised at cycle 2: due pulse at 5 suppressed
        Pause = 1'b1;
        tick(2);
        InReq = 1'b1;
        tick(2);
        chk("inreq_t4_cpuen", 32'(CpuEn), 32'd0);
        tick(1);
        chk("inreq_suppress", 32'(CpuEn), 32'd0);
        chk("inreq_state_rel", 32'(dut.state_q), 32'(IN_WAIT_REL));
        tick(1);
        chk("inreq_state_press", 32'(dut.state_q), 32'(IN_WAIT_PRESS));

        // Valid press captures 0xABC
        Sw    = 14'h2ABC;
        Botao = 1'b0;
        tick(4);
        chk("cap1_pre_cpuen", 32'(CpuEn), 32'd0);
        tick(1);
        chk("cap1_cpuen", 32'(CpuEn), 32'd1);
        chk("cap1_dv", 32'(DataValid), 32'd1);
        chk("cap1_data", DataIn, 32'h0000_0ABC);
        chk("cap1_state", 32'(dut.state_q), 32'(IN_DONE));
        InReq = 1'b0;
        Botao = 1'b1;
        tick(1);
        chk("cap1_post_cpuen", 32'(CpuEn), 32'd0);
        chk("cap1_post_dv", 32'(DataValid), 32'd0);
        chk("cap1_hold", DataIn, 32'h0000_0ABC);
        chk("cap1_post_state", 32'(dut.state_q), 32'(RUN));
        tick(4);
        chk("after_done_t4", 32'(CpuEn), 32'd0);
        tick(1);
        chk("after_done_t5", 32'(CpuEn), 32'd1);

        // Back into IN_WAIT_PRESS via the next run-mode pulse
        InReq = 1'b1;
        tick(5);
        chk("wait2_suppress", 32'(CpuEn), 32'd0);
        tick(1);
        chk("wait2_state", 32'(dut.state_q), 32'(IN_WAIT_PRESS));

        // Invalid press (Sw[13]=0): one InvalidPress, no CpuEn, data unchanged
        Sw    = 14'h0123;
        Botao = 1'b0;
        tick(5);
        chk("inv_pulse", 32'(InvalidPress), 32'd1);
        chk("inv_cpuen", 32'(CpuEn), 32'd0);
        chk("inv_state", 32'(dut.state_q), 32'(IN_WAIT_PRESS));
        chk("inv_data", DataIn, 32'h0000_0ABC);
        Botao = 1'b1;
        tick(1);
        chk("inv_pulse_end", 32'(InvalidPress), 32'd0);
        tick(4);
        Sw    = 14'h3FFF;
        Botao = 1'b0;
        tick(5);
        chk("cap2_cpuen", 32'(CpuEn), 32'd1);
        chk("cap2_dv", 32'(DataValid), 32'd1);
        chk("cap2_data", DataIn, 32'h0000_1FFF);
        InReq = 1'b0;
        Botao = 1'b1;
        tick(8);

        // Step mode: press lands on IN while held 20 cycles; no capture until release
        Pause = 1'b0;
        Sw    = 14'h2055;
        InReq = 1'b1;
        Botao = 1'b0;
        clr_cnt();
        tick_cnt(5);
        chk("step_in_state", 32'(dut.state_q), 32'(IN_WAIT_REL));
        tick_cnt(15);
        chk("step_held_state", 32'(dut.state_q), 32'(IN_WAIT_REL));
        Botao = 1'b1;
        tick_cnt(5);
        chk("step_rel_state", 32'(dut.state_q), 32'(IN_WAIT_PRESS));
        chk("step_no_cpuen", 32'(cnt_cpu), 32'd0);
        chk("step_no_dv", 32'(cnt_dv), 32'd0);
        chk("step_data_kept", DataIn, 32'h0000_1FFF);
        Botao = 1'b0;
        tick(5);
        chk("step_cap_cpuen", 32'(CpuEn), 32'd1);
        chk("step_cap_dv", 32'(DataValid), 32'd1);
        chk("step_cap_data", DataIn, 32'h0000_0055);
        InReq = 1'b0;
        Botao = 1'b1;
        tick(8);

        // Reset asserted while in IN_WAIT_PRESS
        Pause = 1'b1;
        InReq = 1'b1;
        tick(5);
        chk("rstw_suppress", 32'(CpuEn), 32'd0);
        tick(1);
        chk("rstw_state_pre", 32'(dut.state_q), 32'(IN_WAIT_PRESS));
        Reset = 1'b0;
        tick(1);
        chk("rstw_state", 32'(dut.state_q), 32'(RUN));
        chk("rstw_cpuen", 32'(CpuEn), 32'd0);
        chk("rstw_data", DataIn, 32'd0);
        chk("rstw_dv", 32'(DataValid), 32'd0);
        Reset = 1'b1;
        InReq = 1'b0;
        tick(4);
        chk("rstw_t4", 32'(CpuEn), 32'd0);
        tick(1);
        chk("rstw_t5", 32'(CpuEn), 32'd1);
        tick(4);
        chk("rstw_t9", 32'(CpuEn), 32'd0);
        tick(1);
        chk("rstw_t10", 32'(CpuEn), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
